// File: rtl/crypto_tx_pkg.sv
// Shared types and constants for the AES block transmit path.
package crypto_tx_pkg;

    localparam int unsigned BLK_BYTES = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned IDX_W     = $clog2(BLK_BYTES);
    localparam int unsigned BLK_W     = BLK_BYTES * BYTE_W;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStbHi,
        StStbLo
    } tx_state_e;

    // Byte 0 is the most significant byte of the block (MSB-first on the wire).
    // The {idx, 3'b000} shift amount relies on BYTE_W being 8.
    function automatic logic [BYTE_W-1:0] blk_byte(input logic [BLK_W-1:0] blk,
                                                   input logic [IDX_W-1:0] idx);
        logic [BLK_W-1:0] sh;
        sh = blk << {idx, 3'b000};
        return sh[BLK_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops, both cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/block_tx_serializer.sv
// Serialises a 128-bit cipher block as 16 strobed bytes (MSB first) with a
// four-phase STB/ACK handshake and a per-wait timeout.
// Optional build macro: CRYPTO_TX_PARITY_EN adds odd parity on tx_par_o.
module block_tx_serializer
    import crypto_tx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned SETUP_CYC   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [BLK_W-1:0]  blk_data_i,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    output logic [BYTE_W-1:0] tx_data_o,
    output logic              tx_stb_o,
    input  logic              tx_ack_i,
    output logic              tx_par_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic ack;

    sync_2ff u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (tx_ack_i),
        .q_o    (ack)
    );

    tx_state_e         state_q;
    logic [BLK_W-1:0]  blk_q;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        setup_q;
    logic [TmoW-1:0]   tmo_q;
    logic [BYTE_W-1:0] data_q;
    logic              stb_q;
    logic              ready_q;
    logic              busy_q;
    logic              err_q;
    logic [BYTE_W-1:0] cur_byte;

    assign cur_byte = blk_byte(blk_q, idx_q);

    // Handshake FSM; every output is registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            blk_q   <= '0;
            idx_q   <= '0;
            setup_q <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (blk_valid_i && ready_q) begin
                        blk_q   <= blk_data_i;
                        idx_q   <= '0;
                        setup_q <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    // Data is reloaded every setup cycle so it is stable for
                    // SETUP_CYC cycles before the strobe rises.
                    data_q <= cur_byte;
                    if (setup_q == 4'(SETUP_CYC)) begin
                        stb_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= StStbHi;
                    end else begin
                        setup_q <= setup_q + 4'd1;
                    end
                end
                StStbHi: begin
                    if (ack) begin
                        stb_q   <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= StStbLo;
                    end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StStbLo: begin
                    if (!ack) begin
                        if (idx_q == IDX_W'(BLK_BYTES - 1)) begin
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            setup_q <= '0;
                            state_q <= StSetup;
                        end
                    end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef CRYPTO_TX_PARITY_EN
    logic par_q;

    // Odd parity loaded alongside the data register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q <= 1'b0;
        end else if (state_q == StSetup) begin
            par_q <= ~^cur_byte;
        end
    end

    assign tx_par_o = par_q;
`else
    assign tx_par_o = 1'b0;
`endif

    assign blk_ready_o = ready_q;
    assign tx_data_o   = data_q;
    assign tx_stb_o    = stb_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_block_tx_serializer.sv
// Directed bench for block_tx_serializer (TIMEOUT_CYC=16, SETUP_CYC=2).
module tb_block_tx_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [7:0]   tx_data;
    logic         tx_stb;
    logic         tx_ack;
    logic         tx_par;
    logic         busy;
    logic         err;

    block_tx_serializer #(
        .TIMEOUT_CYC (16),
        .SETUP_CYC   (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .blk_data_i  (blk_data),
        .blk_valid_i (blk_valid),
        .blk_ready_o (blk_ready),
        .tx_data_o   (tx_data),
        .tx_stb_o    (tx_stb),
        .tx_ack_i    (tx_ack),
        .tx_par_o    (tx_par),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

`ifdef CRYPTO_TX_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    function automatic logic exp_par(input logic [7:0] b);
        return ParEn ? ~^b : 1'b0;
    endfunction

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Receiver modes: 0 never acks, 1 acks 3 cycles after STB, 2 ack stuck high.
    int           rx_mode = 1;
    logic [2:0]   hist = '0;
    logic         stb_prev = 1'b0;
    int           nstb = 0;
    int           first_rise = 0;
    logic [127:0] got = '0;
    logic [7:0]   data_seen [16];
    logic         par_seen [16];
    int           par_bad = 0;
    int           rdy_busy = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Receiver model and strobe monitor, sampled on the falling edge.
    initial begin
        tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_stb === 1'b1 && stb_prev === 1'b0) begin
                if (nstb < 16) begin
                    data_seen[nstb] = tx_data;
                    par_seen[nstb]  = tx_par;
                end
                if (nstb == 0) first_rise = cyc;
                got = {got[119:0], tx_data};
                nstb++;
                if (tx_par !== exp_par(tx_data)) par_bad++;
            end
            stb_prev = tx_stb;
            if (busy === 1'b1 && blk_ready === 1'b1) rdy_busy++;
            case (rx_mode)
                1:       tx_ack = hist[2];
                2:       tx_ack = 1'b1;
                default: tx_ack = 1'b0;
            endcase
            hist = {hist[1:0], tx_stb};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 500000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_stb(input logic lvl, input int max, input string tag);
        int n = 0;
        while (tx_stb !== lvl && n < max) begin
            tick();
            n++;
        end
        check(tag, 128'(tx_stb), 128'(lvl));
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        check(tag, 128'(busy), 128'(0));
    endtask

    task automatic clr_mon();
        nstb = 0;
        got  = '0;
    endtask

    task automatic send(input logic [127:0] b);
        blk_data  = b;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
    endtask

    logic [127:0] b1, b2, b3, b4, b5, b6, b7;
    int acc, r;

    initial begin
        b1 = 128'h00112233445566778899AABBCCDDEEFF;
        b2 = 128'hFEDCBA98765432100123456789ABCDEF;
        b3 = 128'hC3000000000000000000000000000001;
        b4 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        b5 = 128'h0703A55A0FF0123456789ABCDEF0817E;
        b6 = 128'h9A000000000000000000000000000000;
        b7 = 128'h55AA55AA0102040810204080FF00FF00;

        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        rx_mode   = 1;
        tick();
        tick();
        check("reset_outputs", 128'({blk_ready, busy, err, tx_stb, tx_par, tx_data}), 128'(0));

        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 128'({blk_ready, busy}), 128'(2'b10));

        // Normal block, with a second block held valid throughout.
        clr_mon();
        rdy_busy  = 0;
        blk_data  = b1;
        blk_valid = 1'b1;
        tick();
        acc = cyc;
        check("blk1_accept", 128'({blk_ready, busy}), 128'(2'b01));
        blk_data = b2;
        wait_idle(600, "blk1_done");
        check("blk1_ready_idle", 128'(blk_ready), 128'(1));
        check("blk1_bytes", got, b1);
        check("blk1_strobes", 128'(nstb), 128'(16));
        check("blk1_first_stb", 128'(first_rise - acc), 128'(3));
        check("blk1_err", 128'(err), 128'(0));
        check("ready_during_busy", 128'(rdy_busy), 128'(0));

        clr_mon();
        tick();
        check("blk2_accept", 128'(busy), 128'(1));
        blk_valid = 1'b0;
        wait_idle(600, "blk2_done");
        check("blk2_bytes", got, b2);
        check("blk2_strobes", 128'(nstb), 128'(16));

        // Silent receiver: STB_HI timeout.
        rx_mode = 0;
        repeat (5) tick();
        clr_mon();
        send(b3);
        wait_stb(1'b1, 20, "tmo_stb_rise");
        r = cyc;
        check("tmo_byte0", 128'(tx_data), 128'(b3[127:120]));
        wait_stb(1'b0, 40, "tmo_stb_fall");
        check("tmo_stb_len", 128'(cyc - r), 128'(16));
        check("tmo_flags", 128'({err, blk_ready, busy}), 128'(3'b110));

        // Next block clears ERR; reset lands during byte 7.
        rx_mode = 1;
        clr_mon();
        send(b4);
        check("err_cleared", 128'(err), 128'(0));
        begin
            int n = 0;
            while (nstb < 8 && n < 400) begin
                tick();
                n++;
            end
        end
        check("reached_byte7", 128'(nstb), 128'(8));
        check("byte7_value", 128'(data_seen[7]), 128'(b4[71:64]));
        rst_n = 1'b0;
        #1;
        check("async_reset", 128'({blk_ready, busy, err, tx_stb, tx_par, tx_data}), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_midreset", 128'({blk_ready, busy}), 128'(2'b10));
        repeat (6) tick();
        clr_mon();
        send(b5);
        wait_idle(600, "blk5_done");
        check("blk5_bytes", got, b5);
        check("blk5_byte0", 128'(data_seen[0]), 128'(8'h07));
        check("par_07", 128'(par_seen[0]), 128'(exp_par(8'h07)));
        check("par_03", 128'(par_seen[1]), 128'(exp_par(8'h03)));

        // ACK stuck high: STB_HI exits at once, STB_LO times out.
        rx_mode = 2;
        repeat (4) tick();
        clr_mon();
        send(b6);
        wait_stb(1'b1, 20, "stuck_stb_rise");
        r = cyc;
        tick();
        check("stuck_stb_drop", 128'({tx_stb, busy}), 128'(2'b01));
        begin
            int n = 0;
            while (err !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
        end
        check("stuck_lo_tmo", 128'(cyc - r), 128'(17));
        check("stuck_lo_flags", 128'({err, blk_ready, busy, tx_stb}), 128'(4'b1100));

        // ACK stuck high, then released: transfer resumes and completes.
        clr_mon();
        send(b7);
        check("stuck2_err_clear", 128'(err), 128'(0));
        wait_stb(1'b1, 20, "stuck2_stb_rise");
        tick();
        check("stuck2_stb_drop", 128'(tx_stb), 128'(0));
        repeat (5) tick();
        check("stuck2_waiting", 128'({busy, err, tx_stb}), 128'(3'b100));
        rx_mode = 1;
        wait_idle(600, "blk7_done");
        check("blk7_bytes", got, b7);
        check("blk7_strobes", 128'(nstb), 128'(16));
        check("blk7_err", 128'(err), 128'(0));
        check("parity_all_strobes", 128'(par_bad), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
